// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first).
// Bytes enter through a valid/ready port and are buffered. The FSM pops the
// head whenever the line is free or a stop bit has just finished, so queued
// frames go out back to back with no idle gap.
//
// Handshake: a byte transfers on any posedge where in_valid && in_ready.
// in_ready depends only on the FIFO fill level, never on in_valid. The
// producer holds in_data stable while in_valid is high and unaccepted.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          out_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Transmitter state
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_cnt_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_nxt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic          out_nxt;
  logic          baud_done;

  assign full      = (fifo_count == DEPTH_L);
  assign empty     = (fifo_count == '0);
  assign in_ready  = !full;
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push      = in_valid && !full;
  assign head      = mem[rd_ptr];
  assign baud_done = (baud_cnt == CNT_LAST);
  assign busy      = (state != IDLE) || !empty;

  // FIFO data array; written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and fill level; pointers wrap naturally (depth is 2^AW)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmitter registers; reset forces the line high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      out_data <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      out_data <= out_nxt;
    end
  end

  // Next-state and line value; each state entry restarts the baud counter
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + 1'b1;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    out_nxt      = out_data;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        out_nxt      = 1'b1;
        baud_cnt_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          out_nxt   = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_done) begin
          state_nxt    = DATA;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          out_nxt      = shift[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            out_nxt   = 1'b1;
          end else begin
            shift_nxt   = {1'b0, shift[7:1]};
            out_nxt     = shift[1];
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_cnt_nxt = '0;
          if (!empty) begin
            // Chain straight into the next start bit
            pop       = 1'b1;
            shift_nxt = head;
            out_nxt   = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
            out_nxt   = 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        baud_cnt_nxt = '0;
        out_nxt      = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks uart_tx_fifo against a frame-level model (a byte
// queue plus a position inside the current 10-slot frame), a mid-bit UART
// receiver with a byte scoreboard, and hand-computed cycle expectations.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * DIV;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic       out_data;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];     // bytes waiting in the FIFO
  logic [7:0] exp_q[$];   // bytes still owed on the line
  logic [7:0] rx_log[$];  // bytes decoded by the receiver
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = 8'h00;

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
  endtask

  // Expected line level: slot 0 start, slots 1..8 data LSB first, slot 9 stop
  function automatic logic m_line();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / DIV;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  // One clock of the model; pop decisions use the fill level before the edge
  task automatic model_step();
    bit do_push;
    bit start_new;
    do_push   = in_valid && (m_q.size() < DEPTH);
    start_new = 1'b0;
    if (m_active) begin
      if (m_pos == FRAME - 1) begin
        m_active  = 1'b0;
        start_new = (m_q.size() != 0);
      end else begin
        m_pos++;
      end
    end else begin
      start_new = (m_q.size() != 0);
    end
    if (start_new) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (do_push) begin
      m_q.push_back(in_data);
      exp_q.push_back(in_data);
    end
  endtask

  always @(negedge rst_n) model_reset();

  // ---------------- receiver model (samples mid-bit) ----------------
  bit         rx_active = 1'b0;
  logic       rx_prev   = 1'b1;
  int         rx_t      = 0;
  logic [7:0] rx_byte   = 8'h00;

  task automatic rx_step();
    int k;
    if (!rst_n) begin
      rx_active = 1'b0;
      rx_prev   = 1'b1;
    end else begin
      if (!rx_active) begin
        if (rx_prev && !out_data) begin
          rx_active = 1'b1;
          rx_t      = 0;
        end
      end else begin
        rx_t++;
        if (rx_t == DIV/2) begin
          check("rx_start_bit", 32'(out_data), 32'd0);
        end else if (rx_t > DIV/2 && ((rx_t - DIV/2) % DIV) == 0) begin
          k = (rx_t - DIV/2) / DIV;
          if (k <= 8) begin
            rx_byte[k-1] = out_data;
          end else begin
            check("rx_stop_bit", 32'(out_data), 32'd1);
            if (exp_q.size() == 0) begin
              check("rx_unexpected_byte", 32'(rx_byte), 32'h100);
            end else begin
              check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
            rx_log.push_back(rx_byte);
            rx_active = 1'b0;
          end
        end
      end
      rx_prev = out_data;
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  always begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("out_data",   32'(out_data),   32'(m_line()));
    check("busy",       32'(busy),       32'(m_active || (m_q.size() != 0)));
    check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    check("in_ready",   32'(in_ready),   32'(m_q.size() < DEPTH));
    rx_step();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer a byte and hold it until an edge where in_ready was high
  task automatic push_byte(input logic [7:0] b);
    bit r;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 2000; i++) begin
      r = in_ready;
      tick();
      if (r) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL push_timeout: byte %0h not accepted within 2000 cycles", b);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!busy) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, bound);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // ---------------- stimulus ----------------
  logic exp_wave [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int t0;
    int b0;
    int n0;
    bit line_ok;
    int gap;

    // 1. reset
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t1_out_data",   32'(out_data),   32'd1);
    check("t1_in_ready",   32'(in_ready),   32'd1);
    check("t1_busy",       32'(busy),       32'd0);
    check("t1_fifo_count", 32'(fifo_count), 32'd0);
    line_ok = 1'b1;
    repeat (50) begin
      tick();
      if (out_data !== 1'b1) line_ok = 1'b0;
    end
    check("t1_line_high_50", 32'(line_ok), 32'd1);

    // 2. single byte 0x55
    push_byte(8'h55);
    in_valid = 1'b0;
    t0 = cyc;
    check("t2_count_after_push", 32'(fifo_count), 32'd1);
    check("t2_line_before_pop",  32'(out_data),   32'd1);
    for (int k = 1; k <= 101; k++) begin
      tick();
      if (k == 1)  check("t2_start_first", 32'(out_data), 32'd0);
      if (k == 10) check("t2_start_last",  32'(out_data), 32'd0);
      if (k == 11) check("t2_bit0_first",  32'(out_data), 32'd1);
      if (k >= 6 && k <= 96 && ((k - 6) % 10) == 0)
        check("t2_slot_mid", 32'(out_data), 32'(exp_wave[(k - 6) / 10]));
      if (k == 100) check("t2_busy_last_stop", 32'(busy), 32'd1);
      if (k == 101) check("t2_busy_drop",      32'(busy), 32'd0);
    end
    check("t2_elapsed", 32'(cyc - t0), 32'd101);

    // 3. burst 0x01..0x06 with in_valid held
    b0 = cyc;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    check("t3_five_edges",  32'(cyc - b0),   32'd5);
    check("t3_count_full",  32'(fifo_count), 32'd4);
    check("t3_ready_low",   32'(in_ready),   32'd0);
    push_byte(8'h06);
    in_valid = 1'b0;
    check("t3_06_accept_edge", 32'(cyc - b0), 32'd103);
    wait_idle(1000);
    check("t3_six_frames_span", 32'(cyc - b0), 32'd602);

    // 4. push coinciding with the STOP->START pop
    n0 = rx_log.size();
    b0 = cyc;
    push_byte(8'h3C);
    push_byte(8'hC3);
    in_valid = 1'b0;
    check("t4_idle_pushpop_count", 32'(fifo_count), 32'd1);
    wait_until(b0 + 101);
    check("t4_count_before", 32'(fifo_count), 32'd1);
    push_byte(8'h5A);
    in_valid = 1'b0;
    check("t4_push_edge",     32'(cyc - b0),   32'd102);
    check("t4_count_after",   32'(fifo_count), 32'd1);
    check("t4_back_to_back",  32'(out_data),   32'd0);
    wait_idle(1000);
    check("t4_three_frames_span", 32'(cyc - b0), 32'd302);
    check("t4_rx_count", 32'(rx_log.size() - n0), 32'd3);
    if (rx_log.size() >= n0 + 3) begin
      check("t4_rx0", 32'(rx_log[n0]),   32'h3C);
      check("t4_rx1", 32'(rx_log[n0+1]), 32'hC3);
      check("t4_rx2", 32'(rx_log[n0+2]), 32'h5A);
    end

    // 5. reset during bit 3 of 0xA5 with two bytes queued
    n0 = rx_log.size();
    b0 = cyc;
    push_byte(8'hA5);
    push_byte(8'h11);
    push_byte(8'h22);
    in_valid = 1'b0;
    check("t5_queued", 32'(fifo_count), 32'd2);
    wait_until(b0 + 46);
    check("t5_bit3_low", 32'(out_data), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_line",  32'(out_data),   32'd1);
    check("t5_async_count", 32'(fifo_count), 32'd0);
    check("t5_async_busy",  32'(busy),       32'd0);
    repeat (5) tick();
    @(negedge clk);
    rst_n = 1'b1;
    line_ok = 1'b1;
    repeat (150) begin
      tick();
      if (out_data !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
    end
    check("t5_silent_after_reset", 32'(line_ok), 32'd1);
    check("t5_no_frame_decoded",   32'(rx_log.size() - n0), 32'd0);

    // 6. receiver decode of 0x00, 0xFF, 0x80
    n0 = rx_log.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h80);
    in_valid = 1'b0;
    wait_idle(1000);
    check("t6_rx_count", 32'(rx_log.size() - n0), 32'd3);
    if (rx_log.size() >= n0 + 3) begin
      check("t6_rx0", 32'(rx_log[n0]),   32'h00);
      check("t6_rx1", 32'(rx_log[n0+1]), 32'hFF);
      check("t6_rx2", 32'(rx_log[n0+2]), 32'h80);
    end

    // 7. random bytes with random gaps, some long enough to drain
    for (int i = 0; i < 25; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(50, 250)) : 0;
      repeat (gap) tick();
    end
    wait_idle(3000);
    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter with a built-in byte FIFO: the transmit-side counterpart of the board's RS-232 receive path. It accepts bytes over a valid/ready handshake, buffers them, and serialises each one as 8N1 frames (LSB first) on the `out_data` line. It sits between on-chip byte producers and the TX pin. It also supplies the `busy` status used by the board's activity LED.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 9600: bit rate. Supported values are 9600, 14400, 19200, 38400, 57600 and 115200.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of 2, at least 2.

Derived constant:
- `DIV = CLK_FREQ / BAUD`, using integer truncation. This is the bit period in clocks.
- At the default clock, 115200 baud gives `DIV` = 434.

Ports:
- `clk`, input, 1 bit: clock.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `in_valid`, input, 1 bit: the producer has a byte on `in_data`.
- `in_data`, input, 8 bits: byte to send.
- `in_ready`, output, 1 bit: FIFO can accept a byte. Equals `!full`.
- `out_data`, output, 1 bit: serial TX line. Registered; idles high.
- `busy`, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1 bits: number of bytes currently stored.

## Operation
Reset values:
- `out_data` = 1.
- `in_ready` = 1.
- `busy` = 0.
- `fifo_count` = 0.
- FSM in `IDLE`; baud counter 0; bit index 0.
- FIFO pointers cleared.

FIFO:
- Push happens when `in_valid && in_ready` at a posedge.
- Pop happens when the FSM loads a byte.
- When full, `in_ready` = 0. A push is refused even if a pop occurs in the same cycle.
- A simultaneous push and pop leaves `fifo_count` unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.
- Order is strict FIFO.

FSM states:
- `IDLE`
  - `out_data` = 1.
  - If `fifo_count` > 0, pop the head into an 8-bit shift register, set `out_data` to 0, clear the baud counter, and go to `START`.
- `START`
  - Hold `out_data` = 0 for `DIV` cycles, then go to `DATA` with bit index 0.
  - On entering `DATA`, drive `out_data` = shift[0].
- `DATA`
  - Each bit is held for `DIV` cycles, then the register shifts right.
  - After bit index 7 completes, go to `STOP` with `out_data` = 1.
- `STOP`
  - Hold `out_data` = 1 for `DIV` cycles.
  - If the FIFO is then non-empty, pop, drive `out_data` = 0 and go straight to `START`. There is no idle gap between frames.
  - Otherwise go to `IDLE`.

Baud counter:
- Counts 0 to `DIV`-1.
- Terminal count advances the state or bit.
- Reset to 0 on every state entry.

`busy` = (state != `IDLE`) || (`fifo_count` != 0).

Reset mid-frame: the line returns to 1 immediately (asynchronously), the FIFO is emptied, and the partial frame is discarded.

## Timing
- Push at edge T into an empty FIFO with the FSM in `IDLE`:
  - `fifo_count` = 1 after T.
  - Pop at T+1, so `out_data` falls after edge T+1.
  - Latency from accept to start bit is 1 cycle.
- One frame lasts exactly 10×`DIV` cycles: start bit, 8 data bits with LSB first, then the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the previous stop bit's `DIV`th cycle.
- `in_ready` is combinational from `fifo_count` and has no dependency on `in_valid`.
- Throughput: one byte per 10×`DIV` cycles. The FIFO absorbs bursts up to `FIFO_DEPTH` bytes.

## Test plan
All scenarios use `CLK_FREQ` = 1_000_000, `BAUD` = 100_000 (so `DIV` = 10) and `FIFO_DEPTH` = 4.

1. Reset:
   - Stimulus: hold `rst_n` = 0 for 5 cycles, then release.
   - Required: `out_data` = 1, `in_ready` = 1, `busy` = 0, `fifo_count` = 0, and the line stays high for 50 cycles.
2. Single byte 0x55:
   - Stimulus: push 0x55 at cycle T.
   - Required: `out_data` = 0 for cycles T+1..T+10, then bits 1,0,1,0,1,0,1,0 with 10 cycles each, then 1 for 10 cycles.
   - Required: `busy` drops at T+101.
3. Burst of 6 pushes 0x01..0x06 with `in_valid` held high:
   - Required: the first pushes are accepted. With the first pop at cycle 2, bytes 0x01..0x05 are accepted and `in_ready` goes low with `fifo_count` = 4.
   - Required: 0x06 is accepted once a pop frees a slot.
   - Required: six contiguous frames of 100 cycles each, in order 0x01..0x06, with no idle gap.
4. Simultaneous push and pop at the `STOP`→`START` boundary:
   - Required: `fifo_count` is unchanged and no byte is lost or duplicated.
5. Reset mid-frame:
   - Stimulus: assert `rst_n` = 0 during bit 3 of 0xA5, with 2 more bytes queued.
   - Required: `out_data` = 1 immediately and `fifo_count` = 0.
   - Required: after release, no frame is sent.
6. Frame check with a bench UART receive model:
   - Stimulus: send bytes 0x00, 0xFF and 0x80.
   - Required: each byte is decoded correctly and the stop bit is high in every frame.
